// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, FSM states, BCD operand geometry.
// Also used by the keyboard controller and the ALU.
package calc_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;
  localparam int unsigned CNT_W      = 3;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_ADD       = 4'hA;
  localparam logic [3:0] KEY_SUB       = 4'hB;
  localparam logic [3:0] KEY_MUL       = 4'hC;
  localparam logic [3:0] KEY_DIV       = 4'hD;
  localparam logic [3:0] KEY_EQ        = 4'hE;
  localparam logic [3:0] KEY_CLR       = 4'hF;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_START,
    ST_WAIT,
    ST_SHOW,
    ST_ERROR
  } calc_state_e;

  typedef enum logic [2:0] {
    ENTRY_HOLD,
    ENTRY_CLEAR,
    ENTRY_SHIFT,
    ENTRY_RESTART,
    ENTRY_LOAD
  } entry_cmd_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return k inside {KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV};
  endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// One BCD operand register: left-shift digit entry saturating at four digits,
// plus clear / restart-with-digit / parallel load.
module bcd_entry_reg
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  entry_cmd_e         cmd,
  input  logic [DIGIT_W-1:0] digit,
  input  logic [BCD_W-1:0]   load_val,
  output logic [BCD_W-1:0]   value,
  output logic [CNT_W-1:0]   count,
  output logic [BCD_W-1:0]   value_nxt_c
);

  logic [CNT_W-1:0] count_nxt_c;

  always_comb begin
    value_nxt_c = value;
    count_nxt_c = count;
    case (cmd)
      ENTRY_CLEAR: begin
        value_nxt_c = '0;
        count_nxt_c = '0;
      end
      ENTRY_SHIFT: begin
        // a fifth digit leaves the operand untouched
        if (count < CNT_W'(NUM_DIGITS)) begin
          value_nxt_c = {value[BCD_W-DIGIT_W-1:0], digit};
          count_nxt_c = count + CNT_W'(1);
        end
      end
      ENTRY_RESTART: begin
        value_nxt_c = BCD_W'(digit);
        count_nxt_c = CNT_W'(1);
      end
      ENTRY_LOAD: begin
        value_nxt_c = load_val;
        count_nxt_c = CNT_W'(NUM_DIGITS);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      count <= '0;
    end else begin
      value <= value_nxt_c;
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects two BCD operands and an operator from the
// keypad, hands them to the ALU, and drives the display with the outcome.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic [BCD_W-1:0] alu_res,
  input  logic             alu_done,
  input  logic             alu_err,
  output logic [BCD_W-1:0] alu_num1,
  output logic [BCD_W-1:0] alu_num2,
  output logic [3:0]       alu_op,
  output logic             alu_start,
  output logic [BCD_W-1:0] display,
  output logic             disp_err,
  output logic             busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  calc_state_e       state;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [BCD_W-1:0]  result;
  entry_cmd_e        a_cmd_c;
  entry_cmd_e        b_cmd_c;
  logic [BCD_W-1:0]  a_nxt_c;
  logic [BCD_W-1:0]  b_nxt_c;
  logic [CNT_W-1:0]  a_count_unused;
  logic [CNT_W-1:0]  b_count;
  logic              key_digit_c;
  logic              key_op_c;
  logic              key_eq_c;
  logic              key_clr_c;

  assign key_digit_c = key_valid && is_digit(key_code);
  assign key_op_c    = key_valid && is_op(key_code);
  assign key_eq_c    = key_valid && (key_code == KEY_EQ);
  assign key_clr_c   = key_valid && (key_code == KEY_CLR);

  // Operand register commands; clear overrides every state.
  always_comb begin
    a_cmd_c = ENTRY_HOLD;
    b_cmd_c = ENTRY_HOLD;
    if (key_clr_c) begin
      a_cmd_c = ENTRY_CLEAR;
      b_cmd_c = ENTRY_CLEAR;
    end else begin
      case (state)
        ST_ENTER_A: begin
          if (key_digit_c)   a_cmd_c = ENTRY_SHIFT;
          else if (key_op_c) b_cmd_c = ENTRY_CLEAR;
        end
        ST_ENTER_B: begin
          if (key_digit_c) b_cmd_c = ENTRY_SHIFT;
        end
        ST_SHOW: begin
          if (key_digit_c) begin
            a_cmd_c = ENTRY_RESTART;
          end else if (key_op_c) begin
            a_cmd_c = ENTRY_LOAD;
            b_cmd_c = ENTRY_CLEAR;
          end
        end
        default: ;
      endcase
    end
  end

  bcd_entry_reg u_entry_a (
    .clk         (clk),
    .reset       (reset),
    .cmd         (a_cmd_c),
    .digit       (key_code),
    .load_val    (result),
    .value       (alu_num1),
    .count       (a_count_unused),
    .value_nxt_c (a_nxt_c)
  );

  bcd_entry_reg u_entry_b (
    .clk         (clk),
    .reset       (reset),
    .cmd         (b_cmd_c),
    .digit       (key_code),
    .load_val    (result),
    .value       (alu_num2),
    .count       (b_count),
    .value_nxt_c (b_nxt_c)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ENTER_A;
      alu_op    <= '0;
      alu_start <= 1'b0;
      busy      <= 1'b0;
      display   <= '0;
      disp_err  <= 1'b0;
      result    <= '0;
      tmo_cnt   <= '0;
    end else begin
      alu_start <= 1'b0;
      if (key_clr_c) begin
        state    <= ST_ENTER_A;
        alu_op   <= '0;
        busy     <= 1'b0;
        display  <= '0;
        disp_err <= 1'b0;
        result   <= '0;
        tmo_cnt  <= '0;
      end else begin
        case (state)
          ST_ENTER_A: begin
            if (key_digit_c) begin
              display <= a_nxt_c;
            end else if (key_op_c) begin
              alu_op <= key_code;
              state  <= ST_ENTER_B;
            end
          end
          ST_ENTER_B: begin
            if (key_digit_c) begin
              display <= b_nxt_c;
            end else if (key_op_c && (b_count == '0)) begin
              alu_op <= key_code;
            end else if (key_eq_c && (b_count != '0)) begin
              state     <= ST_START;
              alu_start <= 1'b1;
              busy      <= 1'b1;
              display   <= result;
              tmo_cnt   <= '0;
            end
          end
          ST_START: begin
            // the start cycle already counts toward the timeout
            state   <= ST_WAIT;
            tmo_cnt <= TMO_W'(1);
          end
          ST_WAIT: begin
            if (alu_done) begin
              busy <= 1'b0;
              if (alu_err) begin
                state    <= ST_ERROR;
                display  <= '0;
                disp_err <= 1'b1;
              end else begin
                state   <= ST_SHOW;
                result  <= alu_res;
                display <= alu_res;
              end
            end else if (tmo_cnt >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
              state    <= ST_ERROR;
              busy     <= 1'b0;
              display  <= '0;
              disp_err <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          ST_SHOW: begin
            if (key_digit_c) begin
              state   <= ST_ENTER_A;
              display <= a_nxt_c;
            end else if (key_op_c) begin
              alu_op  <= key_code;
              state   <= ST_ENTER_B;
              display <= result;
            end
          end
          ST_ERROR: ;
          default: state <= ST_ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios then random key streams,
// checked against a behavioural calculator model with a decimal ALU.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int unsigned TMO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] alu_res;
  logic        alu_done;
  logic        alu_err;
  logic [15:0] alu_num1;
  logic [15:0] alu_num2;
  logic [3:0]  alu_op;
  logic        alu_start;
  logic [15:0] display;
  logic        disp_err;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef enum int {PH_A, PH_B, PH_BUSY, PH_SHOW, PH_ERR} phase_e;
  phase_e      m_phase;
  logic [15:0] m_a, m_b, m_res, m_disp;
  int          m_acnt, m_bcnt;
  logic [3:0]  m_op;
  logic        m_err, m_start;

  calc_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .alu_res   (alu_res),
    .alu_done  (alu_done),
    .alu_err   (alu_err),
    .alu_num1  (alu_num1),
    .alu_num2  (alu_num2),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .display   (display),
    .disp_err  (disp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int bcd2int(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int z);
    return {4'(z / 1000), 4'((z / 100) % 10), 4'((z / 10) % 10), 4'(z % 10)};
  endfunction

  // Decimal ALU: negative, >9999 or divide by zero is an error.
  task automatic alu_golden(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                            output logic [15:0] r, output logic e);
    int x, y, z;
    x = bcd2int(a);
    y = bcd2int(b);
    z = 0;
    e = 1'b0;
    case (op)
      4'hA: z = x + y;
      4'hB: z = x - y;
      4'hC: z = x * y;
      default: if (y == 0) e = 1'b1; else z = x / y;
    endcase
    if (z < 0 || z > 9999) e = 1'b1;
    r = e ? 16'h0 : int2bcd(z);
  endtask

  task automatic model_reset();
    m_phase = PH_A;
    m_a = 0; m_b = 0; m_res = 0; m_disp = 0;
    m_acnt = 0; m_bcnt = 0; m_op = 0; m_err = 0; m_start = 0;
  endtask

  task automatic model_key(input logic [3:0] k);
    logic dig, op;
    dig = (k <= 4'h9);
    op  = (k >= 4'hA && k <= 4'hD);
    m_start = 0;
    if (k == 4'hF) begin
      model_reset();
    end else begin
      case (m_phase)
        PH_A: begin
          if (dig) begin
            if (m_acnt < 4) begin m_a = 16'(m_a * 16 + k); m_acnt++; end
            m_disp = m_a;
          end else if (op) begin
            m_op = k; m_b = 0; m_bcnt = 0; m_phase = PH_B;
          end
        end
        PH_B: begin
          if (dig) begin
            if (m_bcnt < 4) begin m_b = 16'(m_b * 16 + k); m_bcnt++; end
            m_disp = m_b;
          end else if (op && m_bcnt == 0) begin
            m_op = k;
          end else if (k == 4'hE && m_bcnt > 0) begin
            m_phase = PH_BUSY; m_start = 1; m_disp = m_res;
          end
        end
        PH_SHOW: begin
          if (dig) begin
            m_a = 16'(k); m_acnt = 1; m_phase = PH_A; m_disp = m_a;
          end else if (op) begin
            m_a = m_res; m_acnt = 4; m_op = k; m_b = 0; m_bcnt = 0;
            m_phase = PH_B; m_disp = m_res;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".num1"},  alu_num1, m_a);
    chk({tag, ".num2"},  alu_num2, m_b);
    chk({tag, ".op"},    16'(alu_op), 16'(m_op));
    chk({tag, ".disp"},  display, m_disp);
    chk({tag, ".err"},   16'(disp_err), 16'(m_err));
    chk({tag, ".busy"},  16'(busy), 16'(m_phase == PH_BUSY));
    chk({tag, ".start"}, 16'(alu_start), 16'(m_start));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(0, 15));
    model_key(k);
    check_all($sformatf("key%h", k));
  endtask

  // Serve one ALU request; done arrives lat cycles after alu_start.
  // mode 0: plain, 1: clear coincides with done, 2: other key coincides with done.
  task automatic run_alu(input int lat, input int mode);
    logic [15:0] r;
    logic        e;
    alu_golden(m_a, m_b, m_op, r, e);
    for (int i = 0; i < lat; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        key_valid = 1'b1;
        key_code  = 4'($urandom_range(0, 14));
      end
      alu_res = 16'($urandom);
      tick();
      key_valid = 1'b0;
      m_start = 0;
      check_all("wait");
    end
    alu_done = 1'b1;
    alu_res  = r;
    alu_err  = e;
    if (mode == 1) begin
      key_valid = 1'b1; key_code = KEY_CLR;
    end else if (mode == 2) begin
      key_valid = 1'b1; key_code = 4'($urandom_range(0, 14));
    end
    tick();
    alu_done = 1'b0; alu_err = 1'b0; key_valid = 1'b0;
    alu_res  = 16'($urandom);
    if (mode == 1) begin
      model_reset();
    end else if (e) begin
      m_phase = PH_ERR; m_disp = 0; m_err = 1;
    end else begin
      m_phase = PH_SHOW; m_res = r; m_disp = r;
    end
    check_all("done");
  endtask

  initial begin
    logic [3:0] k;
    int r;
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    alu_res = 16'h0; alu_done = 1'b0; alu_err = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    check_all("reset");

    // 12 + 34 with a three-cycle ALU
    press(4'h1); press(4'h2); press(KEY_ADD); press(4'h3); press(4'h4); press(KEY_EQ);
    chk("add.start", 16'(alu_start), 16'h1);
    chk("add.num1", alu_num1, 16'h0012);
    chk("add.num2", alu_num2, 16'h0034);
    run_alu(3, 0);
    chk("add.result", display, 16'h0046);
    press(KEY_CLR);

    // fifth digit dropped, operator replaced before any B digit
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    chk("five.num1", alu_num1, 16'h1234);
    press(KEY_ADD); press(KEY_SUB); press(4'h9);
    chk("repl.op", 16'(alu_op), 16'h000B);
    chk("repl.disp", display, 16'h0009);
    press(KEY_CLR);

    // divide by zero -> error, only clear exits
    press(4'h9); press(KEY_DIV); press(4'h0); press(KEY_EQ);
    run_alu(2, 0);
    chk("div0.err", 16'(disp_err), 16'h1);
    chk("div0.disp", display, 16'h0000);
    press(4'h3); press(KEY_ADD); press(KEY_EQ);
    press(KEY_CLR);
    chk("div0.clr", 16'(disp_err), 16'h0);

    // ALU timeout, then a late done
    press(4'h5); press(KEY_MUL); press(4'h2); press(KEY_EQ);
    for (int i = 1; i < int'(TMO); i++) begin
      tick();
      m_start = 0;
      check_all("tmo.wait");
    end
    tick();
    m_phase = PH_ERR; m_disp = 0; m_err = 1;
    check_all("tmo.hit");
    alu_done = 1'b1; alu_res = 16'h0010;
    tick();
    alu_done = 1'b0;
    check_all("tmo.late");
    press(KEY_CLR);

    // chain from result 0x0010, then new entry from SHOW
    press(4'h4); press(KEY_ADD); press(4'h6); press(KEY_EQ);
    run_alu(2, 0);
    chk("chain.r0", display, 16'h0010);
    press(KEY_ADD); press(4'h5); press(KEY_EQ);
    chk("chain.num1", alu_num1, 16'h0010);
    chk("chain.num2", alu_num2, 16'h0005);
    run_alu(1, 0);
    chk("chain.r1", display, 16'h0015);
    press(4'h7);
    chk("new.num1", alu_num1, 16'h0007);
    press(KEY_ADD);
    press(KEY_CLR);

    // reset during WAIT abandons the operation
    press(4'h1); press(KEY_ADD); press(4'h1); press(KEY_EQ);
    tick();
    m_start = 0;
    check_all("rstw.wait");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_all("rstw.reset");
    alu_done = 1'b1; alu_res = 16'h0002;
    tick();
    alu_done = 1'b0;
    check_all("rstw.stale");

    // clear beats a coincident done
    press(4'h2); press(KEY_ADD); press(4'h3); press(KEY_EQ);
    run_alu(2, 1);
    chk("clrdone.disp", display, 16'h0000);

    // random key streams
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      k = 4'($urandom_range(0, 9));
      else if (r < 80) k = 4'($urandom_range(10, 13));
      else if (r < 96) k = KEY_EQ;
      else             k = KEY_CLR;
      press(k);
      if (m_phase == PH_BUSY) begin
        r = int'($urandom_range(0, 7));
        run_alu(int'($urandom_range(1, 6)), (r == 0) ? 1 : (r == 1) ? 2 : 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
